// File: rtl/clock_set_ctrl.sv
// Timebase, count-enable chaining and MODE/INC set-mode FSM for the HH:MM:SS clock.
// Optional INC auto-repeat is built when CLOCK_SET_AUTOREPEAT_EN is defined.
module clock_set_ctrl #(
    parameter int TICK_DIV = 1000
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       sec_wrap,
    input  logic       min_wrap,
    output logic       sec_ce,
    output logic       sec_clr,
    output logic       min_ce,
    output logic       hour_ce,
    output logic [1:0] mode,
    output logic       blank_hour,
    output logic       blank_min
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_HALF = PRE_W'(TICK_DIV / 2);

    localparam logic [1:0] ST_RUN      = 2'b00;
    localparam logic [1:0] ST_SET_HOUR = 2'b01;
    localparam logic [1:0] ST_SET_MIN  = 2'b10;

    logic [PRE_W-1:0] pre, pre_nxt;
    logic [1:0]       mode_nxt;
    logic             btn_mode_q, btn_inc_q;
    logic             tick, mode_rise, inc_rise, inc_pulse, clr_nxt;
    logic             sec_ce_nxt, min_ce_nxt, hour_ce_nxt;

    assign tick      = (pre == PRE_MAX);
    assign mode_rise = btn_mode & ~btn_mode_q;
    assign inc_rise  = btn_inc & ~btn_inc_q;

`ifdef CLOCK_SET_AUTOREPEAT_EN
    localparam int REP_W = $clog2(TICK_DIV + 1);
    localparam logic [REP_W-1:0] REP_FIRE   = REP_W'(TICK_DIV);
    localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(TICK_DIV - TICK_DIV / 4 + 1);

    logic [REP_W-1:0] rep_cnt, rep_nxt;
    logic             rep_fire;

    // rep_cnt is zero when idle; a rise arms it, and it fires each time it reaches TICK_DIV.
    always_comb begin
        rep_nxt  = rep_cnt;
        rep_fire = 1'b0;
        if (((mode != ST_SET_HOUR) && (mode != ST_SET_MIN)) || mode_rise || !btn_inc) begin
            rep_nxt = '0;
        end else if (inc_rise) begin
            rep_nxt = REP_W'(1);
        end else if (rep_cnt != '0) begin
            if (rep_cnt == REP_FIRE) begin
                rep_fire = 1'b1;
                rep_nxt  = REP_RELOAD;
            end else begin
                rep_nxt = rep_cnt + REP_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) rep_cnt <= '0;
        else     rep_cnt <= rep_nxt;
    end

    assign inc_pulse = (inc_rise & ~mode_rise) | rep_fire;
`else
    assign inc_pulse = inc_rise & ~mode_rise;
`endif

    always_comb begin
        mode_nxt = mode;
        clr_nxt  = 1'b0;
        case (mode)
            ST_RUN:      if (mode_rise) mode_nxt = ST_SET_HOUR;
            ST_SET_HOUR: if (mode_rise) mode_nxt = ST_SET_MIN;
            ST_SET_MIN: begin
                if (mode_rise) begin
                    mode_nxt = ST_RUN;
                    clr_nxt  = 1'b1;
                end
            end
            default:     mode_nxt = ST_RUN;
        endcase

        // Leaving set mode restarts the second so the first tick is a full period away.
        if (clr_nxt || tick) pre_nxt = '0;
        else                 pre_nxt = pre + PRE_W'(1);

        sec_ce_nxt  = (mode == ST_RUN) & tick;
        min_ce_nxt  = ((mode == ST_RUN) & tick & sec_wrap) |
                      ((mode == ST_SET_MIN) & inc_pulse);
        hour_ce_nxt = ((mode == ST_RUN) & tick & sec_wrap & min_wrap) |
                      ((mode == ST_SET_HOUR) & inc_pulse);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            mode       <= ST_RUN;
            pre        <= '0;
            btn_mode_q <= 1'b1;
            btn_inc_q  <= 1'b1;
            sec_ce     <= 1'b0;
            sec_clr    <= 1'b0;
            min_ce     <= 1'b0;
            hour_ce    <= 1'b0;
            blank_hour <= 1'b0;
            blank_min  <= 1'b0;
        end else begin
            mode       <= mode_nxt;
            pre        <= pre_nxt;
            btn_mode_q <= btn_mode;
            btn_inc_q  <= btn_inc;
            sec_ce     <= sec_ce_nxt;
            sec_clr    <= clr_nxt;
            min_ce     <= min_ce_nxt;
            hour_ce    <= hour_ce_nxt;
            // Blank from the next-state values so the strobe lines up with the registered pre/mode.
            blank_hour <= (mode_nxt == ST_SET_HOUR) & (pre_nxt >= PRE_HALF);
            blank_min  <= (mode_nxt == ST_SET_MIN) & (pre_nxt >= PRE_HALF);
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl at TICK_DIV=10: pulses are matched against
// an expected queue of {edge index, sec_ce, sec_clr, min_ce, hour_ce}.
module tb_clock_set_ctrl;

    localparam int TD = 10;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       sec_wrap = 1'b0;
    logic       min_wrap = 1'b0;
    logic       sec_ce, sec_clr, min_ce, hour_ce;
    logic [1:0] mode;
    logic       blank_hour, blank_min;

    int         cyc = 0;
    int         errs = 0;
    int         checks = 0;
    int         base, base2, base3, base4;
    logic [19:0] exp_q[$];

    clock_set_ctrl #(.TICK_DIV(TD)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .sec_wrap  (sec_wrap),
        .min_wrap  (min_wrap),
        .sec_ce    (sec_ce),
        .sec_clr   (sec_clr),
        .min_ce    (min_ce),
        .hour_ce   (hour_ce),
        .mode      (mode),
        .blank_hour(blank_hour),
        .blank_min (blank_min)
    );

    // Clock and edge counter
    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic logic [19:0] pk(input int c, input logic [3:0] v);
        logic [15:0] c16;
        c16 = 16'(c);
        return {c16, v};
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks = checks + 1;
        if (act != req) begin
            errs = errs + 1;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk_in);
    endtask

    // Monitor: any pulse must match the head of the expected queue
    always @(negedge clk_in) begin
        logic [3:0]  vec;
        logic [19:0] got, want;
        vec = {sec_ce, sec_clr, min_ce, hour_ce};
        if (vec != 4'b0000) begin
            checks = checks + 1;
            got = pk(cyc, vec);
            if (exp_q.size() == 0) begin
                errs = errs + 1;
                $display("FAIL unexpected_pulse at edge %0d: got pulses %b, expected none", cyc, vec);
            end else begin
                want = exp_q.pop_front();
                if (got != want) begin
                    errs = errs + 1;
                    $display("FAIL pulse at edge %0d: got edge %0d pulses %b, expected edge %0d pulses %b",
                             cyc, got[19:4], got[3:0], want[19:4], want[3:0]);
                end
            end
        end
    end

    initial begin
        // Reset
        repeat (3) @(negedge clk_in);
        check("reset_mode", int'(mode), 0);
        check("reset_blank", int'({blank_hour, blank_min}), 0);
        check("reset_pulses", int'({sec_ce, sec_clr, min_ce, hour_ce}), 0);
        rst  = 1'b0;
        base = cyc;

        // RUN: plain seconds, then full chain, then seconds+minutes only
        exp_q.push_back(pk(base + 10, 4'b1000));
        exp_q.push_back(pk(base + 20, 4'b1000));
        exp_q.push_back(pk(base + 30, 4'b1000));
        exp_q.push_back(pk(base + 40, 4'b1011));
        exp_q.push_back(pk(base + 50, 4'b1011));
        exp_q.push_back(pk(base + 60, 4'b1010));
        for (int e = base + 1; e <= base + 34; e++) begin
            wait_cyc(e);
            check("run_blank", int'({blank_hour, blank_min}), 0);
        end
        wait_cyc(base + 35);
        sec_wrap = 1'b1;
        min_wrap = 1'b1;
        wait_cyc(base + 55);
        min_wrap = 1'b0;
        wait_cyc(base + 65);
        sec_wrap = 1'b0;
        check("run_mode", int'(mode), 0);

        // MODE press 1 -> SET_HOUR, blink on second half of the second
        btn_mode = 1'b1;
        wait_cyc(base + 66);
        btn_mode = 1'b0;
        check("mode_set_hour", int'(mode), 1);
        for (int e = base + 70; e <= base + 79; e++) begin
            wait_cyc(e);
            check("blank_hour", int'(blank_hour), (((e - base) % TD) >= TD / 2) ? 1 : 0);
            check("blank_min_in_hour", int'(blank_min), 0);
        end

        // MODE press 2 -> SET_MIN
        wait_cyc(base + 80);
        btn_mode = 1'b1;
        wait_cyc(base + 81);
        btn_mode = 1'b0;
        check("mode_set_min", int'(mode), 2);
        for (int e = base + 90; e <= base + 99; e++) begin
            wait_cyc(e);
            check("blank_min", int'(blank_min), (((e - base) % TD) >= TD / 2) ? 1 : 0);
            check("blank_hour_in_min", int'(blank_hour), 0);
        end

        // Five INC presses in SET_MIN with min_wrap high: min_ce only
        wait_cyc(base + 100);
        min_wrap = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_cyc(base + 100 + 2 * i);
            btn_inc = 1'b1;
            exp_q.push_back(pk(base + 101 + 2 * i, 4'b0010));
            wait_cyc(base + 101 + 2 * i);
            btn_inc = 1'b0;
        end
        wait_cyc(base + 110);
        min_wrap = 1'b0;

        // MODE press 3 -> RUN with sec_clr, prescaler restarts
        wait_cyc(base + 112);
        btn_mode = 1'b1;
        exp_q.push_back(pk(base + 113, 4'b0100));
        exp_q.push_back(pk(base + 123, 4'b1000));
        wait_cyc(base + 113);
        btn_mode = 1'b0;
        base2 = base + 113;
        check("mode_back_run", int'(mode), 0);
        for (int e = base2 + 1; e <= base2 + 10; e++) begin
            wait_cyc(e);
            check("run_blank2", int'({blank_hour, blank_min}), 0);
        end

        // Simultaneous MODE and INC rise in SET_HOUR: mode advances, no hour_ce
        wait_cyc(base2 + 11);
        btn_mode = 1'b1;
        wait_cyc(base2 + 12);
        btn_mode = 1'b0;
        check("mode_set_hour2", int'(mode), 1);
        wait_cyc(base2 + 13);
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        wait_cyc(base2 + 14);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        check("mode_wins", int'(mode), 2);
        wait_cyc(base2 + 16);
        btn_mode = 1'b1;
        exp_q.push_back(pk(base2 + 17, 4'b0100));
        exp_q.push_back(pk(base2 + 27, 4'b1000));
        wait_cyc(base2 + 17);
        btn_mode = 1'b0;
        base3 = base2 + 17;
        check("mode_back_run2", int'(mode), 0);

        // INC is ignored in RUN
        wait_cyc(base3 + 2);
        btn_inc = 1'b1;
        wait_cyc(base3 + 3);
        btn_inc = 1'b0;

        // Reset mid-set with INC held, then INC held through reset
        wait_cyc(base3 + 12);
        btn_mode = 1'b1;
        wait_cyc(base3 + 13);
        btn_mode = 1'b0;
        wait_cyc(base3 + 14);
        btn_inc = 1'b1;
        exp_q.push_back(pk(base3 + 15, 4'b0001));
        wait_cyc(base3 + 16);
        rst = 1'b1;
        wait_cyc(base3 + 17);
        check("mid_set_reset_mode", int'(mode), 0);
        check("mid_set_reset_blank", int'({blank_hour, blank_min}), 0);
        wait_cyc(base3 + 18);
        rst   = 1'b0;
        base4 = base3 + 18;
        wait_cyc(base4 + 1);
        btn_mode = 1'b1;
        wait_cyc(base4 + 2);
        btn_mode = 1'b0;
        check("mode_after_reset", int'(mode), 1);
        wait_cyc(base4 + 5);
        btn_inc = 1'b0;
        wait_cyc(base4 + 6);
        btn_inc = 1'b1;
        exp_q.push_back(pk(base4 + 7, 4'b0001));
        wait_cyc(base4 + 7);
        btn_inc = 1'b0;

`ifdef CLOCK_SET_AUTOREPEAT_EN
        // Held INC in SET_HOUR: pulse at rise, after TICK_DIV, then every TICK_DIV/4
        wait_cyc(base4 + 9);
        btn_inc = 1'b1;
        exp_q.push_back(pk(base4 + 10, 4'b0001));
        for (int k = 10; k <= 18; k += 2)
            exp_q.push_back(pk(base4 + 10 + k, 4'b0001));
        wait_cyc(base4 + 29);
        btn_inc = 1'b0;
`else
        // Held INC without auto-repeat: a single pulse only
        wait_cyc(base4 + 9);
        btn_inc = 1'b1;
        exp_q.push_back(pk(base4 + 10, 4'b0001));
        wait_cyc(base4 + 29);
        btn_inc = 1'b0;
`endif

        wait_cyc(base4 + 40);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
